// File: rtl/aes_pkg.sv
// aes_pkg: shared types, constants and round-count helper for the AES sequencer
package aes_pkg;
  localparam int AES_BLOCK_BYTES = 16;
  typedef enum logic [1:0] {KEY_128, KEY_192, KEY_256, KEY_BAD} key_mode_t;
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} seq_state_t;
  function automatic logic [3:0] aes_nr(key_mode_t m);
    return m == KEY_192 ? 4'd12 : m == KEY_256 ? 4'd14 : 4'd10;
  endfunction
endpackage

// File: rtl/aes_beat_counter.sv
// aes_beat_counter: beat index within a round, wrapping at BEATS-1 with a wrap pulse
module aes_beat_counter #(
  parameter int BEATS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clear,
  output logic [3:0] count,
  output logic       wrap
);
  localparam logic [3:0] LAST = 4'(BEATS - 1);
  assign wrap = en && count == LAST;
  always_ff @(posedge clk)
    if (rst || clear) count <= '0;
    else if (en) count <= wrap ? '0 : count + 4'd1;
endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: round/beat sequencer driving the AES datapath and round-key memory
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int LANE_BYTES = 1,
  parameter int KEY_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [1:0]            key_mode,
  input  logic                  encrypt,
  input  logic                  beat_valid,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic                  busy,
  output logic                  en_datapath,
  output logic [3:0]            round_counter,
  output logic [3:0]            inner_state_counter,
  output logic                  first_round,
  output logic                  last_round,
  output logic                  load_round_key,
  output logic [KEY_ADDR_W-1:0] addr_round_key_mem,
  output logic                  mode_err
);
  localparam int BEATS = AES_BLOCK_BYTES / LANE_BYTES;
  localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);
  localparam logic [KEY_ADDR_W-1:0] BEATS_A = KEY_ADDR_W'(BEATS);
  localparam logic [KEY_ADDR_W-1:0] BACK_A = KEY_ADDR_W'(2 * BEATS - 1);
  seq_state_t state, state_n;
  logic [3:0] nr, nr_in;
  logic       enc, accept, active, at_last, cnt_en, wrap;
  assign nr_in = aes_nr(key_mode_t'(key_mode));
  assign accept = start_valid && state == IDLE;
  assign active = state == LOAD || state == ROUND || state == FINAL;
  assign at_last = inner_state_counter == LAST_BEAT;
  // the last FINAL beat does not advance, so DONE shows the final round/beat/address
  assign cnt_en = beat_valid && active && !(state == FINAL && at_last);
  assign start_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done_valid = state == DONE;
  assign first_round = state == LOAD;
  assign last_round = state == FINAL;
  assign en_datapath = beat_valid && active;
  assign load_round_key = en_datapath;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = start_valid ? LOAD : IDLE;
      LOAD:  state_n = beat_valid && at_last ? ROUND : LOAD;
      ROUND: state_n = beat_valid && at_last && round_counter == nr - 4'd1 ? FINAL : ROUND;
      FINAL: state_n = beat_valid && at_last ? DONE : FINAL;
      DONE:  state_n = done_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  aes_beat_counter #(.BEATS(BEATS)) u_beat (
    .clk(clk),
    .rst(rst),
    .en(cnt_en),
    .clear(accept),
    .count(inner_state_counter),
    .wrap(wrap)
  );
  // decrypt walks rounds downward: on wrap step back to the start of round R-1
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      nr <= 4'd10;
      enc <= 1'b1;
      round_counter <= '0;
      addr_round_key_mem <= '0;
      mode_err <= 1'b0;
    end else begin
      state <= state_n;
      mode_err <= accept && key_mode == 2'd3;
      if (accept) begin
        nr <= nr_in;
        enc <= encrypt;
        round_counter <= '0;
        addr_round_key_mem <= encrypt ? '0 : KEY_ADDR_W'(nr_in) * BEATS_A;
      end else if (cnt_en) begin
        round_counter <= round_counter + {3'b0, wrap};
        addr_round_key_mem <= enc || !wrap ? addr_round_key_mem + 1'b1 : addr_round_key_mem - BACK_A;
      end
    end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: directed checks over LANE_BYTES 1, 4 and 16 instances
module tb_aes_round_sequencer;
  logic clk = 0;
  logic rst, start_valid, encrypt, beat_valid, done_ready;
  logic [1:0] key_mode;
  logic sr[3], dv[3], bsy[3], en_dp[3], fr[3], lr[3], lrk[3], me[3];
  logic [3:0] rc[3], isc[3];
  logic [7:0] addr[3];
  int vecs = 0, errs = 0, n, bad, frc, lrc, k;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    aes_round_sequencer #(.LANE_BYTES(1 << (2 * g)), .KEY_ADDR_W(8)) u_dut (
      .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr[g]),
      .key_mode(key_mode), .encrypt(encrypt), .beat_valid(beat_valid),
      .done_valid(dv[g]), .done_ready(done_ready), .busy(bsy[g]),
      .en_datapath(en_dp[g]), .round_counter(rc[g]), .inner_state_counter(isc[g]),
      .first_round(fr[g]), .last_round(lr[g]), .load_round_key(lrk[g]),
      .addr_round_key_mem(addr[g]), .mode_err(me[g])
    );
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1;
    tick;
    rst = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 0; start_valid = 0; encrypt = 1; beat_valid = 0; done_ready = 0; key_mode = 0;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      check("rst_start_ready", sr[i], 1);
      check("rst_busy", bsy[i], 0);
      check("rst_done", dv[i], 0);
      check("rst_round", rc[i], 0);
      check("rst_beat", isc[i], 0);
      check("rst_addr", addr[i], 0);
      check("rst_first_last", {fr[i], lr[i], me[i]}, 0);
    end
    beat_valid = 1;
    #1;
    check("idle_en_datapath", {en_dp[0], lrk[0]}, 0);
    // LANE_BYTES=1, AES-128 encrypt
    key_mode = 0; encrypt = 1; start_valid = 1;
    tick;
    start_valid = 0; n = 1; bad = 0; frc = 0; lrc = 0;
    check("t1_load_first", fr[0], 1);
    while (!dv[0] && n < 400) begin
      if (addr[0] !== 8'(n - 1) || lrk[0] !== 1'b1) bad++;
      frc += int'(fr[0]);
      lrc += int'(lr[0]);
      tick;
      n++;
    end
    check("t1_done_cycle", n, 177);
    check("t1_addr_seq", bad, 0);
    check("t1_first_cycles", frc, 16);
    check("t1_last_cycles", lrc, 16);
    check("t1_final_round", rc[0], 10);
    check("t1_final_addr", addr[0], 175);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("hold_done", dv[0], 1);
      check("hold_start_ready", sr[0], 0);
      check("hold_addr", addr[0], 175);
      check("hold_round", rc[0], 10);
      check("hold_beat", isc[0], 15);
    end
    done_ready = 1;
    tick;
    done_ready = 0;
    check("release_idle", sr[0], 1);
    check("release_done_low", dv[0], 0);
    // LANE_BYTES=4, AES-256 decrypt; mode inputs change while busy
    do_reset;
    key_mode = 2; encrypt = 0; start_valid = 1;
    tick;
    start_valid = 0; key_mode = 0; encrypt = 1; n = 1; bad = 0;
    check("t2_first_addr", addr[1], 56);
    while (!dv[1] && n < 400) begin
      k = n - 1;
      if (addr[1] !== 8'((14 - k / 4) * 4 + k % 4)) bad++;
      tick;
      n++;
    end
    check("t2_done_cycle", n, 61);
    check("t2_addr_seq", bad, 0);
    check("t2_final_addr", addr[1], 3);
    check("t2_final_round", rc[1], 14);
    done_ready = 1;
    tick;
    done_ready = 0;
    // LANE_BYTES=16, AES-192 with beat_valid toggling
    do_reset;
    key_mode = 1; encrypt = 1; start_valid = 1;
    tick;
    start_valid = 0; n = 1; bad = 0;
    while (!dv[2] && n < 100) begin
      beat_valid = n[0];
      #1;
      if (rc[2] !== 4'(n / 2) || isc[2] !== 4'd0 || en_dp[2] !== beat_valid) bad++;
      tick;
      n++;
    end
    beat_valid = 1;
    check("t3_done_cycle", n, 26);
    check("t3_stall_seq", bad, 0);
    check("t3_final_round", rc[2], 12);
    check("t3_final_addr", addr[2], 12);
    done_ready = 1;
    tick;
    done_ready = 0;
    // illegal key mode runs 10 rounds; reset aborts the LANE_BYTES=1 run at round 5
    do_reset;
    key_mode = 3; encrypt = 1; start_valid = 1;
    tick;
    start_valid = 0; n = 1;
    check("t4_mode_err_l1", me[0], 1);
    check("t4_mode_err_l16", me[2], 1);
    tick;
    n = 2;
    check("t4_mode_err_pulse", me[0], 0);
    while (n < 12) begin
      tick;
      n++;
    end
    check("t4_l16_done", dv[2], 1);
    check("t4_l16_rounds", rc[2], 10);
    while (rc[0] != 4'd5 && n < 200) begin
      tick;
      n++;
    end
    check("t4_round5_cycle", n, 81);
    rst = 1;
    tick;
    check("t4_abort_start_ready", sr[0], 1);
    check("t4_abort_round", rc[0], 0);
    check("t4_abort_beat", isc[0], 0);
    check("t4_abort_addr", addr[0], 0);
    check("t4_abort_busy", bsy[0], 0);
    rst = 0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (dv[0] !== 1'b0 || sr[0] !== 1'b1) bad++;
      tick;
    end
    check("t4_no_done_after_abort", bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
